uart_tx_mmio: RTL and testbench

//  Memory-mapped UART transmitter on the core's data-memory port, downstream of the core beside mmodel.
//  The top-level address decode steers it core stores/loads in [BASE_ADDR, BASE_ADDR+0xC).

---
 rtl/perips_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 51 +++++
 rtl/uart_tx_mmio.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/perips_pkg.sv
// Shared definitions for the memory-mapped peripherals: UART register offsets,
// STATUS bit positions, transmitter FSM states and the baud reload helper.
package perips_pkg;

    localparam logic [3:0] UART_OFS_TXDATA  = 4'h0;
    localparam logic [3:0] UART_OFS_STATUS  = 4'h4;
    localparam logic [3:0] UART_OFS_DIVISOR = 4'h8;

    localparam int STATUS_FULL      = 0;
    localparam int STATUS_EMPTY     = 1;
    localparam int STATUS_BUSY      = 2;
    localparam int STATUS_OVERFLOW  = 3;
    localparam int STATUS_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // A divisor of 0 behaves like 1, so the counter reload is D-1 with D=max(div,1).
    function automatic logic [15:0] bit_reload(input logic [15:0] div);
        return (div == 16'd0) ? 16'd0 : div - 16'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry one extra wrap bit so full and empty are
// distinguished without a separate counter. Push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which
    // entries are valid, and leaving the array reset-free lets it map to RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/DIVISOR registers, a TX
// FIFO and a bit-serialiser FSM driving a registered, idle-high tx line.
module uart_tx_mmio
    import perips_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_read_req,
    input  logic        mem_write_req,
    input  logic [3:0]  mem_byte_en,
    output logic        mem_hit,
    output logic [31:0] mem_rdata_raw,
    output logic        tx
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]       reg_ofs;
    logic             wr_txdata;
    logic             wr_status;
    logic             wr_div;
    logic [15:0]      div;
    logic             overflow;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [7:0]       fifo_dout;
    logic [CNT_W-1:0] fifo_count;
    logic [31:0]      count_ext;
    logic [3:0]       status_cnt;
    logic [31:0]      status_word;

    uart_state_t state, state_d;
    logic [15:0] baud_cnt, baud_d;
    logic [2:0]  bit_cnt, bit_d;
    logic [7:0]  shreg, shreg_d;
    logic        tx_q, tx_d;
    logic        bit_done;
    logic        unused_bits;

    assign reg_ofs   = {mem_addr[3:2], 2'b00};
    assign mem_hit   = (mem_addr[31:4] == BASE_ADDR[31:4]) && (mem_addr[3:2] != 2'd3);
    assign wr_txdata = mem_hit && mem_write_req && (reg_ofs == UART_OFS_TXDATA) && mem_byte_en[0];
    assign wr_status = mem_hit && mem_write_req && (reg_ofs == UART_OFS_STATUS);
    assign wr_div    = mem_hit && mem_write_req && (reg_ofs == UART_OFS_DIVISOR);
    assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:16], mem_byte_en[3:2]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_txdata),
        .pop   (fifo_pop),
        .din   (mem_wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Full is judged on the pre-edge count, so a push beside a pop on a full FIFO still drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            div      <= DEFAULT_DIV;
            overflow <= 1'b0;
        end else begin
            if (wr_div && mem_byte_en[0]) div[7:0]  <= mem_wdata[7:0];
            if (wr_div && mem_byte_en[1]) div[15:8] <= mem_wdata[15:8];
            if (wr_txdata && fifo_full)
                overflow <= 1'b1;
            else if (wr_status && mem_byte_en[0] && mem_wdata[STATUS_OVERFLOW])
                overflow <= 1'b0;
        end
    end

    assign count_ext  = 32'(fifo_count);
    assign status_cnt = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

    always_comb begin
        status_word = '0;
        status_word[STATUS_FULL]     = fifo_full;
        status_word[STATUS_EMPTY]    = fifo_empty;
        status_word[STATUS_BUSY]     = (state != ST_IDLE);
        status_word[STATUS_OVERFLOW] = overflow;
        status_word[STATUS_COUNT_LSB +: 4] = status_cnt;
    end

    always_comb begin
        mem_rdata_raw = '0;
        if (mem_hit && mem_read_req) begin
            case (reg_ofs)
                UART_OFS_STATUS:  mem_rdata_raw = status_word;
                UART_OFS_DIVISOR: mem_rdata_raw = {16'b0, div};
                default:          mem_rdata_raw = '0;
            endcase
        end
    end

    assign bit_done = (baud_cnt == 16'd0);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d  = state;
        baud_d   = baud_cnt;
        bit_d    = bit_cnt;
        shreg_d  = shreg;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_START;
                    tx_d     = 1'b0;
                    baud_d   = bit_reload(div);
                    shreg_d  = fifo_dout;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = ST_DATA;
                    tx_d    = shreg[0];
                    baud_d  = bit_reload(div);
                    bit_d   = 3'd0;
                end else begin
                    baud_d = baud_cnt - 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    baud_d = bit_reload(div);
                    if (bit_cnt == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_cnt + 3'd1;
                        shreg_d = shreg >> 1;
                        tx_d    = shreg[1];
                    end
                end else begin
                    baud_d = baud_cnt - 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    // Back-to-back frames: go straight into the next start bit.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_START;
                        tx_d     = 1'b0;
                        baud_d   = bit_reload(div);
                        shreg_d  = fifo_dout;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_cnt - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_cnt  <= bit_d;
            shreg    <= shreg_d;
            tx_q     <= tx_d;
        end
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: scoreboard of pushed bytes checked by a
// tx-line decoder, plus cycle-exact waveform checks against frames built from 8N1 rules.
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_read_req = 1'b0;
    logic        mem_write_req = 1'b0;
    logic [3:0]  mem_byte_en = '0;
    logic        mem_hit;
    logic [31:0] mem_rdata_raw;
    logic        tx;

    int n_cmp = 0;
    int n_err = 0;

    bit         mon_en = 1'b0;
    int         cur_d = 4;
    logic [7:0] sb_q[$];
    bit         rec_en = 1'b0;
    logic       log_q[$];
    logic       exp_wave[$];

    always #5 clk = ~clk;

    uart_tx_mmio dut (
        .clk           (clk),
        .rst           (rst),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_read_req  (mem_read_req),
        .mem_write_req (mem_write_req),
        .mem_byte_en   (mem_byte_en),
        .mem_hit       (mem_hit),
        .mem_rdata_raw (mem_rdata_raw),
        .tx            (tx)
    );

    always @(negedge clk) if (rec_en) log_q.push_back(tx);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        mem_addr = addr; mem_wdata = data; mem_byte_en = be; mem_write_req = 1'b1;
        @(posedge clk); #1;
        mem_write_req = 1'b0; mem_byte_en = '0;
    endtask

    task automatic load(input logic [31:0] addr, output logic [31:0] data);
        mem_addr = addr; mem_read_req = 1'b1;
        #1 data = mem_rdata_raw;
        @(posedge clk); #1;
        mem_read_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    function automatic void add_level(input logic lvl, input int n);
        for (int i = 0; i < n; i++) exp_wave.push_back(lvl);
    endfunction

    function automatic void add_frame(input logic [7:0] b, input int d_start, input int d_rest);
        add_level(1'b0, d_start);
        for (int i = 0; i < 8; i++) add_level(b[i], d_rest);
        add_level(1'b1, d_rest);
    endfunction

    // Two leading idle samples: the cycle before and the cycle of the first store edge.
    task automatic start_log();
        log_q.delete();
        exp_wave.delete();
        add_level(1'b1, 2);
        rec_en = 1'b1;
    endtask

    task automatic check_log(input string name);
        int len;
        int budget;
        int bad;
        len = exp_wave.size();
        budget = len + 20;
        while (log_q.size() < len && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        #1 rec_en = 1'b0;
        bad = -1;
        for (int i = 0; i < len; i++)
            if (bad < 0 && (i >= log_q.size() || log_q[i] !== exp_wave[i])) bad = i;
        n_cmp++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL %s: tx sample %0d got %b expected %b (captured %0d of %0d)", name, bad,
                     (bad < log_q.size()) ? log_q[bad] : 1'bx, exp_wave[bad], log_q.size(), len);
        end
    endtask

    // Decoder: samples mid-bit using the divisor in force when the frame starts.
    initial begin
        int d;
        logic [7:0] b;
        forever begin
            @(negedge tx);
            if (mon_en) begin
                d = cur_d;
                repeat (d / 2) @(posedge clk);
                #2 check("mon_start_bit", {31'b0, tx}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (d) @(posedge clk);
                    #2 b[i] = tx;
                end
                repeat (d) @(posedge clk);
                #2 check("mon_stop_bit", {31'b0, tx}, 32'd1);
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL mon_unexpected_frame: got byte 0x%02h expected no frame", b);
                end else begin
                    check("mon_byte", {24'b0, b}, {24'b0, sb_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] r;
        logic [7:0]  byte_v;
        int budget;
        int n;
        int d;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("reset_tx", {31'b0, tx}, 32'd1);
        load(BASE + 32'h4, rd); check("reset_status", rd, 32'h0000_0002);
        load(BASE + 32'h8, rd); check("reset_divisor", rd, 32'h0000_0004);
        load(BASE + 32'h0, rd); check("txdata_reads_zero", rd, 32'h0);

        // Single frame, D=4, exact timing
        mon_en = 1'b1; cur_d = 4;
        start_log(); add_frame(8'h55, 4, 4); add_level(1'b1, 1);
        sb_q.push_back(8'h55);
        store(BASE, 32'h0000_0055, 4'b0001);
        check_log("frame_0x55_wave");
        load(BASE + 32'h4, rd); check("idle_after_frame", rd, 32'h0000_0002);

        // Back-to-back frames, no idle gap
        start_log(); add_frame(8'h41, 4, 4); add_frame(8'h42, 4, 4); add_level(1'b1, 1);
        sb_q.push_back(8'h41); sb_q.push_back(8'h42);
        mem_addr = BASE; mem_byte_en = 4'b0001; mem_write_req = 1'b1; mem_wdata = 32'h41;
        @(posedge clk); #1 mem_wdata = 32'h42;
        @(posedge clk); #1 mem_write_req = 1'b0; mem_byte_en = '0;
        check_log("back_to_back_wave");

        // Randomised bursts checked by the decoder
        for (int k = 0; k < 6; k++) begin
            d = $urandom_range(1, 6);
            store(BASE + 32'h8, d, 4'b0011);
            cur_d = d;
            n = $urandom_range(1, 8);
            for (int j = 0; j < n; j++) begin
                r = $urandom;
                byte_v = r[7:0];
                if (r[8]) store(BASE, r ^ 32'h0000_00FF, {r[11:9], 1'b0});
                sb_q.push_back(byte_v);
                store(BASE, r, {r[14:12], 1'b1});
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            budget = n * 10 * d + 200;
            while (sb_q.size() != 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            #1;
            if (sb_q.size() != 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL drain_timeout: got %0d bytes outstanding expected 0", sb_q.size());
                sb_q.delete();
            end
            repeat (d + 2) @(posedge clk);
            #1;
        end
        mon_en = 1'b0;

        // Divisor change mid-bit, then divisor 0
        store(BASE + 32'h8, 32'd4, 4'b0011);
        start_log(); add_frame(8'h55, 4, 2); add_level(1'b1, 1);
        store(BASE, 32'h55, 4'b0001);
        @(posedge clk); #1;
        store(BASE + 32'h8, 32'd2, 4'b0001);
        check_log("div_change_midbit_wave");
        load(BASE + 32'h8, rd); check("divisor_readback_2", rd, 32'h0000_0002);
        store(BASE + 32'h8, 32'd0, 4'b0011);
        start_log(); add_frame(8'hC3, 1, 1); add_level(1'b1, 1);
        store(BASE, 32'hC3, 4'b0001);
        check_log("div_zero_wave");

        // Overflow with a very slow divisor
        store(BASE + 32'h8, 32'h0000_FFFF, 4'b0011);
        mem_addr = BASE; mem_byte_en = 4'b0001; mem_write_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mem_wdata = $urandom;
            @(posedge clk); #1;
        end
        mem_write_req = 1'b0; mem_byte_en = '0;
        load(BASE + 32'h4, rd); check("overflow_status", rd, 32'h0000_008D);
        store(BASE + 32'h4, 32'h0000_0008, 4'b1110);
        load(BASE + 32'h4, rd); check("ovf_clear_needs_lane0", rd, 32'h0000_008D);
        store(BASE + 32'h4, 32'h0000_0008, 4'b0001);
        load(BASE + 32'h4, rd); check("ovf_cleared", rd, 32'h0000_0085);
        store(BASE, 32'h0000_00AB, 4'b1110);
        load(BASE + 32'h4, rd); check("txdata_lane0_off_ignored", rd, 32'h0000_0085);
        store(BASE + 32'h8, 32'h0000_1234, 4'b0010);
        load(BASE + 32'h8, rd); check("divisor_lane1_only", rd, 32'h0000_12FF);

        do_reset();
        check("post_reset_tx", {31'b0, tx}, 32'd1);
        load(BASE + 32'h4, rd); check("post_reset_status", rd, 32'h0000_0002);
        load(BASE + 32'h8, rd); check("post_reset_divisor", rd, 32'h0000_0004);

        // Reset in the middle of a data bit
        mem_addr = BASE; mem_byte_en = 4'b0001; mem_write_req = 1'b1; mem_wdata = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1 mem_write_req = 1'b0; mem_byte_en = '0;
        repeat (7) @(posedge clk);
        #1 check("pre_reset_data_low", {31'b0, tx}, 32'd0);
        do_reset();
        check("reset_mid_frame_tx", {31'b0, tx}, 32'd1);
        load(BASE + 32'h4, rd); check("reset_mid_frame_status", rd, 32'h0000_0002);
        start_log(); add_level(1'b1, 60);
        check_log("no_residual_frame");

        // Address decode boundaries
        mem_addr = BASE + 32'hC; mem_read_req = 1'b1;
        #1 check("hit_0xC", {31'b0, mem_hit}, 32'd0);
        check("rdata_0xC", mem_rdata_raw, 32'h0);
        mem_addr = BASE + 32'h10;
        #1 check("hit_0x10", {31'b0, mem_hit}, 32'd0);
        mem_addr = BASE + 32'h4; mem_read_req = 1'b0;
        #1 check("hit_status_no_read", {31'b0, mem_hit}, 32'd1);
        check("rdata_no_read", mem_rdata_raw, 32'h0);

        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
